// File: rtl/pipo_arbiter.sv
// pipo_arbiter: round-robin arbiter feeding one shared parallel-in/parallel-out
// register. A granted requester's word is captured into q, after which the
// register is held locked for HOLD cycles before the next load is accepted.
//
// Optional feature: define PIPO_ARB_STATS_EN to add an 8-bit wrapping
// load_count output that counts issued grants (unaffected by clr).
module pipo_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int HOLD  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*WIDTH-1:0]      din,
  output logic [NREQ-1:0]            gnt,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [$clog2(NREQ)-1:0]    q_owner,
  output logic                       busy
`ifdef PIPO_ARB_STATS_EN
  ,
  output logic [7:0]                 load_count
`endif
);

  localparam int PW = $clog2(NREQ);

  // Counter value loaded on entry to HOLD; unused when HOLD is 0.
  localparam logic [7:0] HOLD_RELOAD = (HOLD > 0) ? 8'(HOLD - 1) : 8'd0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [PW-1:0]     ptr, ptr_nxt;
  logic [WIDTH-1:0]  q_nxt;
  logic              q_valid_nxt;
  logic [PW-1:0]     q_owner_nxt;
  logic [NREQ-1:0]   gnt_nxt;
  logic              load;

  logic [WIDTH-1:0]  words [NREQ];
  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic [PW:0]       scan_sum;
  logic [PW-1:0]     scan_idx;

  // Unpack the requester words so the winner can be selected by index.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign words[i] = din[i*WIDTH +: WIDTH];
  end

  // Round-robin scan: first requesting index starting at ptr, wrapping mod NREQ.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr} + (PW+1)'(k);
      if (scan_sum >= (PW+1)'(NREQ)) begin
        scan_sum = scan_sum - (PW+1)'(NREQ);
      end
      scan_idx = scan_sum[PW-1:0];
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state and next-register logic; clr has priority over any load.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ptr_nxt     = ptr;
    q_nxt       = q;
    q_valid_nxt = q_valid;
    q_owner_nxt = q_owner;
    gnt_nxt     = '0;
    load        = 1'b0;

    if (clr) begin
      state_nxt   = ST_IDLE;
      cnt_nxt     = '0;
      q_nxt       = '0;
      q_valid_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            load        = 1'b1;
            q_nxt       = words[win_idx];
            q_valid_nxt = 1'b1;
            q_owner_nxt = win_idx;
            gnt_nxt     = NREQ'(1) << win_idx;
            ptr_nxt     = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            if (HOLD > 0) begin
              state_nxt = ST_HOLD;
              cnt_nxt   = HOLD_RELOAD;
            end
          end
        end
        ST_HOLD: begin
          if (cnt == 8'd0) begin
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, pointer, counter and shared register flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ptr     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      q_owner <= '0;
      gnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ptr     <= ptr_nxt;
      q       <= q_nxt;
      q_valid <= q_valid_nxt;
      q_owner <= q_owner_nxt;
      gnt     <= gnt_nxt;
    end
  end

  assign busy = (state == ST_HOLD);

`ifdef PIPO_ARB_STATS_EN
  // Grant counter; wraps naturally at 8 bits and ignores clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_count <= '0;
    end else if (load) begin
      load_count <= load_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipo_arbiter.sv
// tb_pipo_arbiter: directed bench for pipo_arbiter. Instance dut uses HOLD=2,
// instance dut0 uses HOLD=0 for streaming and (with PIPO_ARB_STATS_EN) the
// grant counter.
module tb_pipo_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, clr0;
  logic [3:0]  req, req0;
  logic [15:0] din, din0;
  logic [3:0]  gnt, gnt0;
  logic [3:0]  q, q0;
  logic        q_valid, q_valid0;
  logic [1:0]  q_owner, q_owner0;
  logic        busy, busy0;
`ifdef PIPO_ARB_STATS_EN
  logic [7:0]  lc, lc0;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pipo_arbiter #(.NREQ(4), .WIDTH(4), .HOLD(2)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .din(din),
    .gnt(gnt), .q(q), .q_valid(q_valid), .q_owner(q_owner), .busy(busy)
`ifdef PIPO_ARB_STATS_EN
    , .load_count(lc)
`endif
  );

  pipo_arbiter #(.NREQ(4), .WIDTH(4), .HOLD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr0), .req(req0), .din(din0),
    .gnt(gnt0), .q(q0), .q_valid(q_valid0), .q_owner(q_owner0), .busy(busy0)
`ifdef PIPO_ARB_STATS_EN
    , .load_count(lc0)
`endif
  );

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; req0 = '0; clr = 1'b0; clr0 = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; clr0 = 1'b0;
    req = 4'b1111; req0 = 4'b1111;
    din = 16'h4321; din0 = 16'h0065;
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++;
      if ({gnt, q, q_valid, busy, q_owner} !== 12'h000) begin
        tests_failed++;
        $display("FAIL reset_outputs cyc%0d got gnt=%b q=%h v=%b busy=%b own=%0d want all 0",
                 c, gnt, q, q_valid, busy, q_owner);
      end
      tests_run++;
      if (gnt0 !== 4'b0000) begin
        tests_failed++;
        $display("FAIL reset_gnt0 got %b want 0000", gnt0);
      end
`ifdef PIPO_ARB_STATS_EN
      tests_run++;
      if (lc !== 8'd0) begin
        tests_failed++;
        $display("FAIL reset_load_count got %0d want 0", lc);
      end
`endif
    end
    req = '0; req0 = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    din = 16'h0A00;
    req = 4'b0100;
    step();
    tests_run++;
    if (q !== 4'hA || gnt !== 4'b0100 || q_owner !== 2'd2 || q_valid !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_load got q=%h gnt=%b own=%0d v=%b busy=%b want q=a gnt=0100 own=2 v=1 busy=1",
               q, gnt, q_owner, q_valid, busy);
    end
    req = '0;
    step();
    tests_run++;
    if (gnt !== 4'b0000 || busy !== 1'b1 || q !== 4'hA) begin
      tests_failed++;
      $display("FAIL single_hold1 got gnt=%b busy=%b q=%h want gnt=0000 busy=1 q=a", gnt, busy, q);
    end
    step();
    tests_run++;
    if (busy !== 1'b0 || gnt !== 4'b0000 || q !== 4'hA) begin
      tests_failed++;
      $display("FAIL single_idle got busy=%b gnt=%b q=%h want busy=0 gnt=0000 q=a", busy, gnt, q);
    end
  endtask

  task automatic test_round_robin();
    int         exp_idx;
    logic [3:0] exp_gnt;
    logic [3:0] exp_q;
    do_reset();
    din = 16'h4321;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_idx = i % 4;
      exp_gnt = 4'b0001 << exp_idx;
      exp_q   = 4'(exp_idx + 1);
      step();
      tests_run++;
      if (gnt !== exp_gnt || q !== exp_q || q_owner !== 2'(exp_idx) || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL rr_grant%0d got gnt=%b q=%h own=%0d busy=%b want gnt=%b q=%h own=%0d busy=1",
                 i, gnt, q, q_owner, busy, exp_gnt, exp_q, exp_idx);
      end
      if (i == 4) req = '0;
      for (int h = 0; h < 2; h++) begin
        step();
        tests_run++;
        if (gnt !== 4'b0000 || q !== exp_q || busy !== (h == 0)) begin
          tests_failed++;
          $display("FAIL rr_hold%0d_%0d got gnt=%b q=%h busy=%b want gnt=0000 q=%h busy=%b",
                   i, h, gnt, q, busy, exp_q, (h == 0));
        end
      end
    end
  endtask

  task automatic test_clr_mid_hold();
    din = 16'h4321;
    req = 4'b0010;
    step();
    tests_run++;
    if (gnt !== 4'b0010 || q !== 4'h2 || q_owner !== 2'd1) begin
      tests_failed++;
      $display("FAIL clr_pre_grant got gnt=%b q=%h own=%0d want gnt=0010 q=2 own=1", gnt, q, q_owner);
    end
    req = 4'b1001;
    clr = 1'b1;
    step();
    tests_run++;
    if (q !== 4'h0 || q_valid !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0 || q_owner !== 2'd1) begin
      tests_failed++;
      $display("FAIL clr_effect got q=%h v=%b gnt=%b busy=%b own=%0d want q=0 v=0 gnt=0000 busy=0 own=1",
               q, q_valid, gnt, busy, q_owner);
    end
    clr = 1'b0;
    step();
    tests_run++;
    if (gnt !== 4'b1000 || q !== 4'h4 || q_owner !== 2'd3 || q_valid !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL clr_ptr_kept got gnt=%b q=%h own=%0d v=%b busy=%b want gnt=1000 q=4 own=3 v=1 busy=1",
               gnt, q, q_owner, q_valid, busy);
    end
    req = '0;
    step();
    step();
  endtask

  task automatic test_rst_mid_hold();
    din = 16'h4321;
    req = 4'b0100;
    step();
    tests_run++;
    if (gnt !== 4'b0100 || q !== 4'h3 || q_owner !== 2'd2) begin
      tests_failed++;
      $display("FAIL rst_pre_grant got gnt=%b q=%h own=%0d want gnt=0100 q=3 own=2", gnt, q, q_owner);
    end
    req = '0;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({gnt, q, q_valid, busy, q_owner} !== 12'h000) begin
      tests_failed++;
      $display("FAIL rst_async got gnt=%b q=%h v=%b busy=%b own=%0d want all 0",
               gnt, q, q_valid, busy, q_owner);
    end
    req = 4'b1001;
    rst_n = 1'b1;
    step();
    tests_run++;
    if (gnt !== 4'b0001 || q !== 4'h1 || q_owner !== 2'd0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_first_load got gnt=%b q=%h own=%0d busy=%b want gnt=0001 q=1 own=0 busy=1",
               gnt, q, q_owner, busy);
    end
    req = '0;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_gnt;
    logic [3:0] exp_q;
    din0 = 16'h0065;
    req0 = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      exp_gnt = (i % 2 == 0) ? 4'b0001 : 4'b0010;
      exp_q   = (i % 2 == 0) ? 4'h5 : 4'h6;
      step();
      tests_run++;
      if (gnt0 !== exp_gnt || q0 !== exp_q || busy0 !== 1'b0 || q_valid0 !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream%0d got gnt=%b q=%h busy=%b v=%b want gnt=%b q=%h busy=0 v=1",
                 i, gnt0, q0, busy0, q_valid0, exp_gnt, exp_q);
      end
    end
    req0 = '0;
    step();
    tests_run++;
    if (gnt0 !== 4'b0000) begin
      tests_failed++;
      $display("FAIL stream_idle got gnt=%b want 0000", gnt0);
    end
  endtask

`ifdef PIPO_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    tests_run++;
    if (lc0 !== 8'd0) begin
      tests_failed++;
      $display("FAIL stats_reset got %0d want 0", lc0);
    end
    din0 = 16'h0065;
    req0 = 4'b0011;
    repeat (130) step();
    clr0 = 1'b1;
    step();
    tests_run++;
    if (lc0 !== 8'd130 || q_valid0 !== 1'b0 || gnt0 !== 4'b0000) begin
      tests_failed++;
      $display("FAIL stats_clr got lc=%0d v=%b gnt=%b want lc=130 v=0 gnt=0000", lc0, q_valid0, gnt0);
    end
    clr0 = 1'b0;
    repeat (127) step();
    tests_run++;
    if (lc0 !== 8'd1) begin
      tests_failed++;
      $display("FAIL stats_wrap got %0d want 1", lc0);
    end
    req0 = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_clr_mid_hold();
    test_rst_mid_hold();
    test_back_to_back();
`ifdef PIPO_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipo_arbiter.md
# pipo_arbiter

Round-robin arbiter and load sequencer for a shared parallel-in/parallel-out register. Up to NREQ requesters each present a WIDTH-bit word and a request. The block grants one requester at a time, captures that word into its internal PIPO register, then holds the register stable for a programmable number of cycles. It sits between the requesting logic and every consumer of the shared register output.

## Interface
- NREQ, 4: number of requesters (2..8).
- WIDTH, 4: data width of each requester word and of the register.
- HOLD, 2: cycles the register stays locked after a load (0..255); 0 permits back-to-back loads.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of register and FSM.
- req  in  NREQ  per-requester load request, level-sensitive.
- din  in  NREQ*WIDTH  requester words, packed; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot, one-cycle grant pulse, registered.
- q  out  WIDTH  shared register contents.
- q_valid  out  1  high once q holds a granted word; low after reset or clr.
- q_owner  out  clog2(NREQ)  index of the requester whose word is in q.
- busy  out  1  high while in HOLD.

## Operation
- FSM has two states:
  - IDLE: accepts a new load.
  - HOLD: q is locked and req is ignored.
- Reset (rst_n low, asynchronous) sets:
  - state IDLE, q=0, q_valid=0, q_owner=0, gnt=0, busy=0.
  - Round-robin pointer ptr=0, so requester 0 has highest priority.
  - Hold counter=0.
- IDLE with any req bit high: the winner is the first set bit scanning ptr, ptr+1, … mod NREQ. At the edge:
  - q is loaded with the winner's din slice; q_owner is set to the winner; q_valid is set to 1.
  - gnt is set to the winner's one-hot code; ptr is set to winner+1 mod NREQ.
  - If HOLD>0: go to HOLD with counter=HOLD-1 and busy=1. If HOLD=0: stay in IDLE.
- IDLE with req=0: nothing changes, and gnt is 0 on the next cycle.
- HOLD:
  - gnt is 0 and q, q_owner and ptr are frozen.
  - At each edge the counter decrements. When the counter is 0 at an edge, the FSM goes to IDLE and busy is cleared.
- clr high at an edge:
  - q=0, q_valid=0, gnt=0, state IDLE, busy=0, counter=0.
  - ptr and q_owner are unchanged.
  - clr overrides a simultaneous load, so no grant is issued that cycle.
- Requester rules:
  - Keep req and din stable until gnt is seen.
  - Dropping req before grant is legal and withdraws the request.
  - If req is still high in IDLE after a grant, it counts as a new request at the rotated priority.
- Maximum load rate is one load per HOLD+1 cycles.

## Timing
- Load latency is 1 cycle: req is sampled at edge N; q, gnt, q_owner and q_valid are updated after edge N.
- gnt is high for exactly one cycle per load, coincident with the new q.
- For HOLD=h, after a load at edge N:
  - busy is high after edges N..N+h-1.
  - IDLE returns after edge N+h.
  - The next load can occur at edge N+h+1.
- An async reset asserted mid-HOLD takes effect immediately. After rst_n deasserts, the first edge with req high produces a load.

## Configuration
- PIPO_ARB_STATS_EN defined:
  - Adds output load_count, 8 bits, reset 0.
  - load_count increments by 1 on every edge that issues a grant and wraps 255→0.
  - clr does not affect it.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset check: drive rst_n=0 with req=4'b1111 → q=0, q_valid=0, gnt=0, busy=0, q_owner=0, and no grant while reset is held.
- Single request (HOLD=2): req=4'b0100, din[11:8]=4'hA → one cycle later q=4'hA, gnt=4'b0100 for one cycle, q_owner=2, busy high for 2 cycles, then IDLE.
- Round-robin fairness: req=4'b1111 held, with din slice i equal to i+1 → grants in order 0,1,2,3,0 spaced HOLD+1 cycles apart, q sequence 1,2,3,4,1.
- HOLD=0 streaming: req=4'b0011 held → a grant every cycle alternating 0,1,0,1; busy stays 0.
- clr and reset mid-HOLD:
  - clr pulse one cycle after a grant → q=0, q_valid=0, IDLE on the next cycle; a pending req is granted at the following edge with ptr unchanged.
  - Repeat with rst_n pulsed low instead of clr → all outputs at reset values immediately.
- With PIPO_ARB_STATS_EN defined: run 257 grants → load_count=1; a clr partway through leaves load_count unaffected.
